// File: rtl/rca_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit rca pass per cycle, LSB nibble first.
// Ports: clk, rst_n, in_valid/in_ready/a/b/cin (operands), out_valid/out_ready/sum/cout (result), busy.
// Optional macro RCA_SERIAL_SUB_EN adds input sub (1 = a - b, cout = no borrow).

module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module rca_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [3:0]       nib_s, nib_b;
    logic             nib_co;
    logic             accept, inv_b, carry_init;

`ifdef RCA_SERIAL_SUB_EN
    logic sub_reg;
    assign inv_b      = sub_reg;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign inv_b      = 1'b0;
    assign carry_init = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Subtraction is a + ~b + 1: invert b nibbles, preload carry with 1.
    assign nib_b = b_reg[4*idx +: 4] ^ {4{inv_b}};

    rca u_rca (
        .a  (a_reg[4*idx +: 4]),
        .b  (nib_b),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (idx == LAST) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef RCA_SERIAL_SUB_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && accept) begin
                a_reg <= a;
                b_reg <= b;
                idx   <= '0;
                carry <= carry_init;
`ifdef RCA_SERIAL_SUB_EN
                sub_reg <= sub;
`endif
            end
            if (state == RUN) begin
                sum[4*idx +: 4] <= nib_s;
                carry           <= nib_co;
                if (idx == LAST) begin
                    cout <= nib_co;
                    idx  <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule
